// File: rtl/mdu_pkg.sv
// Shared MDU definitions: operation encodings, FSM states and default latencies.
package mdu_pkg;

  typedef enum logic [2:0] {
    OpNop   = 3'b000,
    OpMult  = 3'b001,
    OpMultu = 3'b010,
    OpDiv   = 3'b011,
    OpDivu  = 3'b100,
    OpMthi  = 3'b101,
    OpMtlo  = 3'b110,
    OpRsvd  = 3'b111
  } mdu_op_e;

  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StRun  = 1'b1
  } mdu_state_e;

  localparam int unsigned MultCyclesDef = 5;
  localparam int unsigned DivCyclesDef  = 10;

  function automatic logic is_mult(mdu_op_e op);
    return (op == OpMult) || (op == OpMultu);
  endfunction

endpackage

// File: rtl/mdu_if.sv
// Request/result bundle between the issuing pipeline (master) and the MDU (slave).
interface mdu_if;
  logic [31:0] A;
  logic [31:0] B;
  logic [2:0]  MDUOp;
  logic        start;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (
    output A, B, MDUOp, start,
    input  busy, HI, LO
  );

  modport slave (
    input  A, B, MDUOp, start,
    output busy, HI, LO
  );
endinterface

// File: rtl/mdu_div.sv
// Combinational 32-bit quotient/remainder unit; signed mode truncates toward zero and
// gives the remainder the dividend's sign. Outputs are zero for a zero divisor.
module mdu_div (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        signed_i,
  output logic [31:0] quo_o,
  output logic [31:0] rem_o
);

  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] q_mag;
  logic [31:0] r_mag;

  always_comb begin
    a_neg = signed_i & a_i[31];
    b_neg = signed_i & b_i[31];
    // Magnitude of 0x80000000 is still representable as unsigned 32 bits.
    a_mag = a_neg ? (32'd0 - a_i) : a_i;
    b_mag = b_neg ? (32'd0 - b_i) : b_i;
    if (b_mag == 32'd0) begin
      q_mag = 32'd0;
      r_mag = 32'd0;
    end else begin
      q_mag = a_mag / b_mag;
      r_mag = a_mag % b_mag;
    end
    quo_o = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
    rem_o = a_neg ? (32'd0 - r_mag) : r_mag;
  end

endmodule

// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit with HI/LO registers and MTHI/MTLO moves.
// Define MDU_DIV_EN to build the divider; otherwise DIV/DIVU behave as NOP.
module mdu
  import mdu_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MultCyclesDef,
  parameter int unsigned DIV_CYCLES  = DivCyclesDef
) (
  input logic  clk,
  input logic  reset_n,
  mdu_if.slave bus
);

  localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);

  mdu_state_e      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  mdu_op_e         op_q, op_d;
  logic [31:0]     a_q, a_d;
  logic [31:0]     b_q, b_d;
  logic [31:0]     hi_q, hi_d;
  logic [31:0]     lo_q, lo_d;

  mdu_op_e         op_in;
  logic [63:0]     a_ext;
  logic [63:0]     b_ext;
  logic [63:0]     prod;

  assign op_in = mdu_op_e'(bus.MDUOp);

  // Low 64 bits of the extended product equal the signed or unsigned full product.
  always_comb begin
    a_ext = (op_q == OpMult) ? {{32{a_q[31]}}, a_q} : {32'd0, a_q};
    b_ext = (op_q == OpMult) ? {{32{b_q[31]}}, b_q} : {32'd0, b_q};
    prod  = a_ext * b_ext;
  end

`ifdef MDU_DIV_EN
  logic [31:0] quo;
  logic [31:0] rem;

  mdu_div u_div (
    .a_i      (a_q),
    .b_i      (b_q),
    .signed_i (op_q == OpDiv),
    .quo_o    (quo),
    .rem_o    (rem)
  );
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          unique case (op_in)
            OpMult, OpMultu: begin
              state_d = StRun;
              cnt_d   = CntW'(MULT_CYCLES);
              op_d    = op_in;
              a_d     = bus.A;
              b_d     = bus.B;
            end
`ifdef MDU_DIV_EN
            OpDiv, OpDivu: begin
              state_d = StRun;
              cnt_d   = CntW'(DIV_CYCLES);
              op_d    = op_in;
              a_d     = bus.A;
              b_d     = bus.B;
            end
`endif
            OpMthi:  hi_d = bus.A;
            OpMtlo:  lo_d = bus.A;
            default: ;
          endcase
        end
      end

      StRun: begin
        if (cnt_q <= CntW'(1)) begin
          state_d = StIdle;
          cnt_d   = '0;
          if (is_mult(op_q)) begin
            hi_d = prod[63:32];
            lo_d = prod[31:0];
          end
`ifdef MDU_DIV_EN
          // A zero divisor still burns the full latency but leaves HI/LO alone.
          else if (b_q != 32'd0) begin
            hi_d = rem;
            lo_d = quo;
          end
`endif
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      op_q    <= OpNop;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign bus.busy = (state_q == StRun);
  assign bus.HI   = hi_q;
  assign bus.LO   = lo_q;

endmodule

// File: doc/mdu.md
MDU -- requirements
Module: mdu

Interface
REQ-001 Parameter MULT_CYCLES, default 5: number of busy cycles for MULT/MULTU.
REQ-002 Parameter DIV_CYCLES, default 10: number of busy cycles for DIV/DIVU.
REQ-003 clk  input  1: single clock; all state changes on the rising edge.
REQ-004 reset_n  input  1: reset, asynchronous, active-low.
REQ-005 A  input  32: operand 1 (rs value); sole source for MTHI/MTLO.
REQ-006 B  input  32: operand 2 (rt value).
REQ-007 MDUOp  input  3: operation code: 000 NOP, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO, 111 reserved (treated as NOP).
REQ-008 start  input  1: one-cycle request qualifier for MDUOp.
REQ-009 busy  output  1: high while an operation is in flight.
REQ-010 HI  output  32: HI register.
REQ-011 LO  output  32: LO register.

Function
REQ-012 The block SHALL have states IDLE and RUN.
- IDLE -> RUN on start=1 with MDUOp in {MULT, MULTU, DIV, DIVU}.
- RUN -> IDLE when the cycle counter expires.
REQ-013 On an accepted operation, the block SHALL latch the operands and the op, and load the counter with MULT_CYCLES or DIV_CYCLES.
REQ-014 busy SHALL be high from the cycle after acceptance for exactly N cycles; it SHALL be combinational from state only.
REQ-015 HI and LO SHALL update on the clock edge that ends the last busy cycle, and SHALL be valid in the first cycle with busy=0.
REQ-016 Multiply results:
- MULT: {HI,LO} = signed A * signed B.
- MULTU: {HI,LO} = unsigned A * unsigned B, full 64-bit.
REQ-017 Divide results:
- DIV: LO = signed quotient truncated toward zero; HI = remainder with the sign of the dividend.
- DIVU: unsigned quotient and remainder.
REQ-018 Division with B=0 SHALL run the full DIV_CYCLES and leave HI and LO unchanged.
REQ-019 Signed DIV of 0x80000000 by 0xFFFFFFFF SHALL give LO=0x80000000, HI=0.
REQ-020 MTHI/MTLO with start=1 in IDLE SHALL write A into HI/LO at that edge, with no busy cycle.
REQ-021 Any start while busy=1 SHALL be ignored; the pipeline stalls before issuing.
REQ-022 start with NOP or the reserved op SHALL have no effect.
REQ-023 HI and LO SHALL hold their values at all times other than the updates in REQ-015/REQ-020.
REQ-024 Operand changes during RUN SHALL not affect the result.

Reset
REQ-025 While reset_n=0, asynchronously: state=IDLE, counter=0, busy=0, HI=0, LO=0.
REQ-026 Reset during RUN SHALL abort the operation with no HI/LO update.
REQ-027 The first start SHALL be accepted on the first rising edge after reset_n deasserts.

Configuration
REQ-028 Macro MDU_DIV_EN defined: DIV/DIVU SHALL be implemented per REQ-017 to REQ-019.
REQ-029 Macro MDU_DIV_EN undefined:
- No divider logic SHALL be synthesized.
- DIV/DIVU SHALL be treated as NOP: no busy, and HI/LO unchanged.

Structure
REQ-030 Shared package mdu_pkg SHALL hold the MDUOp encodings and the default MULT_CYCLES/DIV_CYCLES constants; the decoder/controller imports it.
REQ-031 One sub-module mdu_div SHALL be used: a combinational signed/unsigned 32-bit quotient/remainder unit, instantiated only under MDU_DIV_EN.
REQ-032 The multiply SHALL be a 64-bit product computed from the latched operands inside mdu.

Verification
REQ-033 The bench SHALL cover the following directed scenarios:
- MULT A=0xFFFFFFFE (-2), B=3 -> busy high 5 cycles -> HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- MULTU A=0xFFFFFFFF, B=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001 after 5 busy cycles.
- DIV A=0xFFFFFFF9 (-7), B=2 -> busy 10 cycles -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU A=7, B=0 after MTHI 0x12345678 -> HI=0x12345678 and LO unchanged after 10 busy cycles.
- MULT start, then MTLO start at busy cycle 2 -> MTLO ignored; final LO is the product.
- reset_n low at DIV busy cycle 4 -> busy=0, HI=LO=0 immediately; MTHI 0xA5 next cycle -> HI=0xA5.
